// File: rtl/bsg_priority_dequeue.sv
// Collects sparse request bits and issues one pending index per cycle; optional rotating priority via BSG_PRIORITY_DEQUEUE_ROUND_ROBIN_EN.
// Latency: set_i in cycle t -> pending_o at t+1 -> v_o/addr_o at t+2. Backpressure: v_o/addr_o hold until yumi_i; pending keeps accumulating.
module bsg_priority_dequeue #(
  parameter int width_p         = 16,
  parameter int lg_width_p      = $clog2(width_p),
  parameter int dup_cnt_width_p = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       set_v_i,
  input  logic [width_p-1:0]         set_i,
  output logic                       v_o,
  output logic [lg_width_p-1:0]      addr_o,
  input  logic                       yumi_i,
  output logic [width_p-1:0]         pending_o,
  output logic                       empty_o,
  output logic [dup_cnt_width_p-1:0] dup_cnt_o
);

  logic [width_p-1:0]         pending_r;
  logic                       v_r;
  logic [lg_width_p-1:0]      addr_r;
  logic [dup_cnt_width_p-1:0] dup_cnt_r;

  logic                       sel_v;
  logic [lg_width_p-1:0]      sel_idx;
  logic                       load;
  logic [width_p-1:0]         clear_mask;
  logic [width_p-1:0]         set_mask;
  logic                       dup_hit;

  assign sel_v = |pending_r;

`ifdef BSG_PRIORITY_DEQUEUE_ROUND_ROBIN_EN
  logic [lg_width_p-1:0] last_r;
  logic [lg_width_p-1:0] start_idx;
  logic [lg_width_p-1:0] probe_idx;

  // Index arithmetic wraps naturally because width_p is a power of two.
  assign start_idx = last_r + lg_width_p'(1);

  always_comb begin
    sel_idx   = '0;
    probe_idx = '0;
    for (int k = width_p - 1; k >= 0; k--) begin
      probe_idx = start_idx + lg_width_p'(k);
      if (pending_r[probe_idx]) sel_idx = probe_idx;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) last_r <= lg_width_p'(width_p - 1);
    else if (load)  last_r <= sel_idx;
  end
`else
  always_comb begin
    sel_idx = '0;
    for (int i = width_p - 1; i >= 0; i--) begin
      if (pending_r[i]) sel_idx = lg_width_p'(i);
    end
  end
`endif

  assign load       = sel_v & (~v_r | yumi_i);
  assign clear_mask = load ? (width_p'(1) << sel_idx) : '0;
  assign set_mask   = set_v_i ? set_i : '0;
  // A bit re-set in its own clear cycle stays pending, so it is not a duplicate.
  assign dup_hit    = |(set_mask & pending_r & ~clear_mask);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pending_r <= '0;
      v_r       <= 1'b0;
      addr_r    <= '0;
      dup_cnt_r <= '0;
    end else begin
      pending_r <= (pending_r & ~clear_mask) | set_mask;
      if (load) begin
        v_r    <= 1'b1;
        addr_r <= sel_idx;
      end else if (yumi_i) begin
        v_r <= 1'b0;
      end
      if (dup_hit && (dup_cnt_r != '1))
        dup_cnt_r <= dup_cnt_r + dup_cnt_width_p'(1);
    end
  end

  assign v_o       = v_r;
  assign addr_o    = addr_r;
  assign pending_o = pending_r;
  assign empty_o   = ~sel_v & ~v_r;
  assign dup_cnt_o = dup_cnt_r;

endmodule

// File: tb/tb_bsg_priority_dequeue.sv
// Directed bench for bsg_priority_dequeue: reset, drain order, back-pressure, duplicates, same-cycle set/clear, priority.
module tb_bsg_priority_dequeue;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        set_v = 1'b0;
  logic [15:0] set_bits = '0;
  logic        yumi = 1'b0;
  logic        v;
  logic [3:0]  addr;
  logic [15:0] pending;
  logic        empty;
  logic [7:0]  dup_cnt;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  bsg_priority_dequeue #(.width_p(16), .lg_width_p(4), .dup_cnt_width_p(8)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .set_v_i   (set_v),
    .set_i     (set_bits),
    .v_o       (v),
    .addr_o    (addr),
    .yumi_i    (yumi),
    .pending_o (pending),
    .empty_o   (empty),
    .dup_cnt_o (dup_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    set_v = 1'b0; set_bits = '0; yumi = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_v", v, 0);
    chk("rst_addr", addr, 0);
    chk("rst_pending", pending, 0);
    chk("rst_empty", empty, 1);
    chk("rst_dup", dup_cnt, 0);
    tick();
    reset_n = 1'b1;

    // Valid but all-zero set vector issues nothing
    set_v = 1'b1; set_bits = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("zero_v", v, 0);
      chk("zero_empty", empty, 1);
    end
    chk("zero_dup", dup_cnt, 0);

    // Drain 16'h8421 lowest-first: 0,5,10,15
    set_bits = 16'h8421;
    tick();
    set_v = 1'b0; set_bits = '0;
    chk("drain_pend", pending, 16'h8421);
    chk("drain_v_t1", v, 0);
    tick();
    chk("drain_v0", v, 1);
    chk("drain_a0", addr, 0);
    yumi = 1'b1;
    tick(); chk("drain_a5", addr, 5);
    tick(); chk("drain_a10", addr, 10);
    tick(); chk("drain_a15", addr, 15); chk("drain_v15", v, 1);
    tick();
    chk("drain_done_v", v, 0);
    chk("drain_done_empty", empty, 1);
    yumi = 1'b0;

    // Back-pressure holds addr_o while pending accumulates
    set_v = 1'b1; set_bits = 16'h0006;
    tick();
    set_v = 1'b0; set_bits = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_v", v, 1);
      chk("bp_addr", addr, 1);
      chk("bp_pend", pending, 16'h0004);
    end
    yumi = 1'b1;
    tick();
    chk("bp_addr2", addr, 2);
    chk("bp_v2", v, 1);
    chk("bp_pend2", pending, 0);
    tick();
    chk("bp_end_v", v, 0);
    chk("bp_end_empty", empty, 1);
    yumi = 1'b0;

    // Duplicate counter: 298 hits over 300 cycles saturates at FF
    set_v = 1'b1; set_bits = 16'h0010;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 9) chk("dup_mid", dup_cnt, 8);
    end
    chk("dup_sat", dup_cnt, 8'hFF);
    chk("dup_v", v, 1);
    chk("dup_addr", addr, 4);
    chk("dup_pend", pending, 16'h0010);
    set_v = 1'b0; set_bits = '0;
    yumi = 1'b1;
    tick();
    chk("dup_reissue", addr, 4);
    chk("dup_pend_clr", pending, 0);
    tick();
    chk("dup_drain_v", v, 0);
    chk("dup_hold", dup_cnt, 8'hFF);
    yumi = 1'b0;

    // Asynchronous reset mid-operation clears an un-yumied output
    set_v = 1'b1; set_bits = 16'h0030;
    tick();
    set_v = 1'b0; set_bits = '0;
    tick();
    chk("mid_v_pre", v, 1);
    reset_n = 1'b0;
    #2;
    chk("mid_v", v, 0);
    chk("mid_pend", pending, 0);
    chk("mid_dup", dup_cnt, 0);
    chk("mid_empty", empty, 1);
    tick();
    reset_n = 1'b1;

    // Set on the bit being cleared in the load cycle wins
    set_v = 1'b1; set_bits = 16'h0001;
    tick();
    chk("sc_pend0", pending, 16'h0001);
    chk("sc_v0", v, 0);
    tick();
    chk("sc_v", v, 1);
    chk("sc_addr", addr, 0);
    chk("sc_pend", pending, 16'h0001);
    chk("sc_dup", dup_cnt, 0);
    set_v = 1'b0; set_bits = '0;
    yumi = 1'b1;
    tick();
    chk("sc_again_v", v, 1);
    chk("sc_again_addr", addr, 0);
    chk("sc_again_pend", pending, 0);
    tick();
    chk("sc_end_v", v, 0);
    yumi = 1'b0;

`ifdef BSG_PRIORITY_DEQUEUE_ROUND_ROBIN_EN
    // Rotating priority with every bit kept pending: 0..15 then wrap to 0
    do_reset();
    set_v = 1'b1; set_bits = 16'hFFFF;
    tick();
    tick();
    chk("rr_first", addr, 0);
    yumi = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("rr_seq", addr, i % 16);
    end
`else
    // Fixed priority with bits 0,1 refilled every cycle always picks 0
    do_reset();
    set_v = 1'b1; set_bits = 16'h0003;
    tick();
    tick();
    chk("fp_first", addr, 0);
    yumi = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("fp_v", v, 1);
      chk("fp_addr", addr, 0);
    end
`endif
    set_v = 1'b0; set_bits = '0; yumi = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
